// File: rtl/rb_commit_unit.sv
// Reorder buffer: allocates entries at issue, snoops per-entry CDB results, retires the head in program order.
// Latency: a result seen valid at edge N commits at edge N+1; rf_we/mem_req are registered outputs.
// Backpressure: alloc_ready drops when full; a store at the head blocks younger commits until mem_ack.
module rb_commit_unit #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 3,
    parameter int REG_INDEX = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_valid,
    input  logic                          alloc_is_store,
    input  logic [REG_INDEX-1:0]          alloc_dest,
    output logic                          alloc_ready,
    output logic [RB_INDEX-1:0]           alloc_index,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    input  logic [RB_SIZE-1:0]            CDB_data_valid,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_addr,
    output logic                          rf_we,
    output logic [REG_INDEX-1:0]          rf_waddr,
    output logic [WORD_SIZE-1:0]          rf_wdata,
    output logic                          mem_req,
    output logic [WORD_SIZE-1:0]          mem_addr,
    output logic [WORD_SIZE-1:0]          mem_wdata,
    input  logic                          mem_ack,
    input  logic                          flush,
    output logic [RB_INDEX:0]             count,
    output logic [RB_INDEX-1:0]           commit_index
);

    typedef enum logic {ST_IDLE, ST_STORE_WAIT} state_e;

    typedef struct packed {
        logic                 busy;
        logic                 is_store;
        logic [REG_INDEX-1:0] dest;
        logic                 seen_low;
        logic                 done;
        logic [WORD_SIZE-1:0] data;
        logic [WORD_SIZE-1:0] addr;
    } rb_entry_t;

    localparam logic [RB_INDEX:0] FULL_CNT = (RB_INDEX+1)'(RB_SIZE);

    state_e               state_q, state_d;
    rb_entry_t            ent_q [RB_SIZE];
    rb_entry_t            ent_d [RB_SIZE];
    logic [RB_INDEX-1:0]  head_q, head_d;
    logic [RB_INDEX-1:0]  tail_q, tail_d;
    logic [RB_INDEX:0]    count_q, count_d;
    logic                 rf_we_q, rf_we_d;
    logic [REG_INDEX-1:0] rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
    logic                 mem_req_q, mem_req_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic                 accept;
    logic                 commit_fire;
    rb_entry_t            head_ent;

    // Held low during reset so every output reads zero while it is asserted.
    assign alloc_ready  = reset && (count_q != FULL_CNT);
    assign alloc_index  = tail_q;
    assign count        = count_q;
    assign commit_index = head_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ent_d       = ent_q;
        commit_fire = 1'b0;
        accept      = alloc_valid && alloc_ready;
        head_ent    = ent_q[head_q];

        // A valid bit only counts after it has been seen low, so a previous occupant's
        // lingering valid cannot complete a freshly allocated entry.
        for (int i = 0; i < RB_SIZE; i++) begin
            if (ent_q[i].busy) begin
                if (!CDB_data_valid[i]) begin
                    ent_d[i].seen_low = 1'b1;
                end else if (ent_q[i].seen_low && !ent_q[i].done) begin
                    ent_d[i].done = 1'b1;
                    ent_d[i].data = CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
                    ent_d[i].addr = CDB_data_addr[i*WORD_SIZE +: WORD_SIZE];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (head_ent.busy && head_ent.done) begin
                    if (head_ent.is_store) begin
                        mem_req_d   = 1'b1;
                        mem_addr_d  = head_ent.addr;
                        mem_wdata_d = head_ent.data;
                        state_d     = ST_STORE_WAIT;
                    end else begin
                        rf_we_d     = 1'b1;
                        rf_waddr_d  = head_ent.dest;
                        rf_wdata_d  = head_ent.data;
                        commit_fire = 1'b1;
                    end
                end
            end
            ST_STORE_WAIT: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    commit_fire = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_fire) begin
            ent_d[head_q].busy     = 1'b0;
            ent_d[head_q].done     = 1'b0;
            ent_d[head_q].seen_low = 1'b0;
            head_d                 = head_q + RB_INDEX'(1);
        end

        // Never collides with the head being freed: accept needs a free slot.
        if (accept) begin
            ent_d[tail_q].busy     = 1'b1;
            ent_d[tail_q].is_store = alloc_is_store;
            ent_d[tail_q].dest     = alloc_dest;
            ent_d[tail_q].seen_low = 1'b0;
            ent_d[tail_q].done     = 1'b0;
            tail_d                 = tail_q + RB_INDEX'(1);
        end

        case ({accept, commit_fire})
            2'b10:   count_d = count_q + (RB_INDEX+1)'(1);
            2'b01:   count_d = count_q - (RB_INDEX+1)'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int i = 0; i < RB_SIZE; i++) begin
                ent_d[i].busy     = 1'b0;
                ent_d[i].done     = 1'b0;
                ent_d[i].seen_low = 1'b0;
            end
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            rf_we_d   = 1'b0;
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < RB_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            for (int i = 0; i < RB_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
